// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N:1 valid/ready mux-arbiter.
package mux_arb_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request above ptr, wrapping.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N     = 16,
  parameter int SEL_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int   c;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    // k=N lands back on ptr itself, so it has lowest priority
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (en && !found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N:1 registered mux/arbiter, explicit-select or round-robin.
// Define MUX_ARB_LOCK_EN to add the burst lock input.
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int SEL_W = idx_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
`ifdef MUX_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             load;
  logic             sel_ok;
  logic             xfer;
  logic             lock_on;
  logic             rr_en;
  logic [N-1:0]     sel_gnt;
  logic [N-1:0]     rr_req;
  logic [N-1:0]     rr_gnt;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] xfer_idx;

  assign load   = !out_valid || out_ready;
  assign sel_ok = int'(sel) < N;
  assign rr_en  = (mode == MODE_RR);

  always_comb begin
    sel_gnt = '0;
    if (sel_ok) begin
      if (in_valid[sel]) sel_gnt = N'(1) << sel;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  logic burst;

  assign lock_on = lock && burst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst <= 1'b0;
    end else if (xfer && rr_en) begin
      burst <= 1'b1;
    end else if (!lock) begin
      burst <= 1'b0;
    end
  end
`else
  assign lock_on = 1'b0;
`endif

  // a locked burst narrows the request set to the last winner
  assign rr_req = lock_on ? (in_valid & (N'(1) << rr_ptr)) : in_valid;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr (
    .req     (rr_req),
    .ptr     (rr_ptr),
    .en      (rr_en),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  assign grant    = rr_en ? rr_gnt : sel_gnt;
  assign in_ready = grant & {N{load}};
  assign xfer     = |(in_ready & in_valid);
  assign xfer_idx = rr_en ? rr_idx : sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(xfer_idx)*WIDTH +: WIDTH];
      out_src   <= xfer_idx;
      if (rr_en) rr_ptr <= xfer_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Self-checking bench for mux_arb_nto1 with a behavioural reference model.
module tb_mux_arb_nto1;
  import mux_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int SEL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic               mode = 1'b0;
  logic [SEL_W-1:0]   sel = '0;
  logic               lock = 1'b0;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready = 1'b1;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_arb_nto1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_ptr;
  logic             m_burst;

  function automatic logic [WIDTH-1:0] chan(input int i);
    return in_data[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic lock_act();
`ifdef MUX_ARB_LOCK_EN
    return lock && m_burst && mode;
`else
    return 1'b0;
`endif
  endfunction

  // channel that would be granted now, -1 if none
  function automatic int m_gnt();
    if (mode == MODE_SEL)
      return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    if (lock_act())
      return in_valid[m_ptr] ? m_ptr : -1;
    for (int k = 1; k <= N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int m_cur();
    if (m_valid && !out_ready) return -1;
    return m_gnt();
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g;
    g = m_cur();
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= 0;
      m_ptr   <= N - 1;
      m_burst <= 1'b0;
    end else begin
      if (m_cur() >= 0) begin
        m_valid <= 1'b1;
        m_data  <= chan(m_cur());
        m_src   <= m_cur();
        if (mode) m_ptr <= m_cur();
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      m_burst <= (m_cur() >= 0 && mode) ? 1'b1 : (lock ? m_burst : 1'b0);
    end
  end

  task automatic set_pattern();
    for (int i = 0; i < N; i++)
      in_data[i*WIDTH +: WIDTH] = 32'hA000_0000 + i;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '1;
    mode = MODE_SEL;
    sel = '0;
    out_ready = 1'b1;
    set_pattern();
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_valid: got %0b expected 0", out_valid);
    if (out_valid !== 1'b0) fails++;
    tests_run++;
    if (out_data !== '0) begin
      $display("FAIL reset_data: got %0h expected 0", out_data);
      fails++;
    end
    tests_run++;
    if (out_src !== '0) begin
      $display("FAIL reset_src: got %0d expected 0", out_src);
      fails++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sel_sweep();
    mode = MODE_SEL;
    in_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      if (k > 0) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_src !== SEL_W'(k - 1) ||
            out_data !== 32'hA000_0000 + k - 1) begin
          $display("FAIL sel_sweep_out: got v=%0b src=%0d data=%0h expected src=%0d data=%0h",
                   out_valid, out_src, out_data, k - 1, 32'hA000_0000 + k - 1);
          fails++;
        end
      end
      if (k < N) begin
        sel = SEL_W'(k);
        #1;
        tests_run++;
        if (in_ready !== (N'(1) << k)) begin
          $display("FAIL sel_sweep_ready: got %0h expected %0h", in_ready, N'(1) << k);
          fails++;
        end
      end
    end
    in_valid = ~(N'(1) << 5);
    sel = 5;
    #1;
    tests_run++;
    if (in_ready !== '0) begin
      $display("FAIL sel_invalid_ready: got %0h expected 0", in_ready);
      fails++;
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      $display("FAIL sel_invalid_xfer: got out_valid %0b expected 0", out_valid);
      fails++;
    end
  endtask

  task automatic test_rr_fair();
    mode = MODE_RR;
    in_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_src !== SEL_W'(k % N) ||
          out_data !== 32'hA000_0000 + (k % N)) begin
        $display("FAIL rr_fair_out: step %0d got v=%0b src=%0d expected src=%0d",
                 k, out_valid, out_src, k % N);
        fails++;
      end
      tests_run++;
      if (in_ready !== (N'(1) << ((k + 1) % N))) begin
        $display("FAIL rr_fair_ready: got %0h expected %0h",
                 in_ready, N'(1) << ((k + 1) % N));
        fails++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_d;
    int               held_s;
    @(negedge clk);
    out_ready = 1'b0;
    held_d = m_data;
    held_s = m_src;
    tests_run++;
    if (out_src !== '0 || held_s != 0) begin
      $display("FAIL bp_load_src: got %0d expected 0", out_src);
      fails++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== held_d || in_ready !== '0) begin
        $display("FAIL bp_hold: got v=%0b data=%0h rdy=%0h expected data=%0h rdy=0",
                 out_valid, out_data, in_ready, held_d);
        fails++;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== SEL_W'((held_s + 1) % N)) begin
      $display("FAIL bp_release: got v=%0b src=%0d expected src=%0d",
               out_valid, out_src, (held_s + 1) % N);
      fails++;
    end
  endtask

  task automatic test_sparse();
    @(negedge clk);
    mode = MODE_RR;
    out_ready = 1'b1;
    in_valid = 16'h0001;
    @(negedge clk);
    in_valid = 16'h8001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_src !== SEL_W'((k % 2 == 0) ? 15 : 0)) begin
        $display("FAIL sparse_wrap: step %0d got src=%0d expected %0d",
                 k, out_src, (k % 2 == 0) ? 15 : 0);
        fails++;
      end
    end
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    @(negedge clk);
    mode = MODE_RR;
    out_ready = 1'b1;
    lock = 1'b0;
    in_valid = 16'h0008;
    @(negedge clk);
    in_valid = '1;
    lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_src !== SEL_W'(3)) begin
        $display("FAIL lock_hold: step %0d got src=%0d expected 3", k, out_src);
        fails++;
      end
    end
    lock = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_src !== SEL_W'(4)) begin
      $display("FAIL lock_release: got src=%0d expected 4", out_src);
      fails++;
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== m_valid || out_data !== m_data ||
          out_src !== SEL_W'(m_src)) begin
        $display("FAIL random_out: cyc %0d got v=%0b d=%0h s=%0d expected v=%0b d=%0h s=%0d",
                 c, out_valid, out_data, out_src, m_valid, m_data, m_src);
        fails++;
      end
      for (int i = 0; i < N; i++)
        in_data[i*WIDTH +: WIDTH] = $urandom;
      in_valid = N'($urandom & $urandom);
      mode = 1'($urandom);
      sel = SEL_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_LOCK_EN
      lock = 1'($urandom);
`endif
      #1;
      tests_run++;
      if (in_ready !== m_ready()) begin
        $display("FAIL random_ready: cyc %0d got %0h expected %0h", c, in_ready, m_ready());
        fails++;
      end
    end
    lock = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    mode = MODE_RR;
    in_valid = '1;
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin
      $display("FAIL midrst_load: got v=%0b expected 1", out_valid);
      fails++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
      $display("FAIL midrst_clear: got v=%0b d=%0h s=%0d expected all 0",
               out_valid, out_data, out_src);
      fails++;
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_src !== '0 || out_valid !== 1'b1) begin
      $display("FAIL midrst_first: got v=%0b s=%0d expected v=1 s=0", out_valid, out_src);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_sel_sweep();
    test_rr_fair();
    test_backpressure();
    test_sparse();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
